logic_unit_pipe: RTL and testbench

Parametrised, registered successor to the single-bit XOR cell. Performs a WIDTH-bit bitwise operation selected by Op: AND, OR, XOR, NOR, XNOR, NAND, XOR-accumulate, or accumulator clear. Has a one-deep valid/ready output stage, Zero and Parity flags, and a saturating count of accepted operations. Sits beside the ALU in the 24-bit datapath; it serves logic instructions and running XOR checksums.

---
 rtl/logic_unit_pipe_pkg.sv | 30 +++
 rtl/logic_unit_pipe_op.sv | 50 +++++
 rtl/logic_unit_pipe.sv | 105 ++++++++++
 tb/tb_logic_unit_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package     : logic_unit_defs
// Description : Operation encodings shared by logic_unit_pipe and its
//               combinational operation stage.
//               OP_AND..OP_NAND are plain bitwise operations.
//               OP_ACC_XOR folds A^B into the running accumulator.
//               OP_ACC_CLR returns the accumulator to its initial value.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_defs;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND     = 3'b000;
  localparam op_t OP_OR      = 3'b001;
  localparam op_t OP_XOR     = 3'b010;
  localparam op_t OP_NOR     = 3'b011;
  localparam op_t OP_XNOR    = 3'b100;
  localparam op_t OP_NAND    = 3'b101;
  localparam op_t OP_ACC_XOR = 3'b110;
  localparam op_t OP_ACC_CLR = 3'b111;

  // True for the operations that write the accumulator.
  function automatic logic is_acc_op(input op_t op);
    return (op == OP_ACC_XOR) || (op == OP_ACC_CLR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_unit_pipe_op.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_comb
// Description : Purely combinational operation stage of logic_unit_pipe.
//               Ports:
//                 A, B     - operands
//                 Op       - operation select (see logic_unit_defs)
//                 acc      - current accumulator value
//                 result   - value to be registered into Out
//                 acc_next - accumulator value to register on accept
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_comb
  import logic_unit_defs::*;
#(
  parameter int                 WIDTH    = 24,
  parameter logic [WIDTH-1:0]   ACC_INIT = '0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc_next
);

  always_comb begin
    result   = '0;
    acc_next = acc;   // non-accumulator ops leave the accumulator alone
    case (Op)
      OP_AND:     result = A & B;
      OP_OR:      result = A | B;
      OP_XOR:     result = A ^ B;
      OP_NOR:     result = ~(A | B);
      OP_XNOR:    result = ~(A ^ B);
      OP_NAND:    result = ~(A & B);
      OP_ACC_XOR: begin
        acc_next = acc ^ A ^ B;
        result   = acc ^ A ^ B;
      end
      OP_ACC_CLR: begin
        acc_next = ACC_INIT;
        result   = ACC_INIT;
      end
      default:    result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Registered WIDTH-bit logic unit with a one-deep valid/ready
//               output stage, Zero/Parity flags, an XOR accumulator and a
//               saturating count of accepted operations.
//               Ports:
//                 Clock, Reset        - rising-edge clock, async high reset
//                 InValid / InReady   - input handshake (InReady is comb.)
//                 A, B, Op            - operands and operation select
//                 OutValid / OutReady - output handshake
//                 Out, Zero, Parity   - registered result and its flags
//                 AccOut              - registered accumulator
//                 Count               - accepted operations, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe
  import logic_unit_defs::*;
#(
  parameter int               WIDTH    = 24,
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Parity,
  output logic [WIDTH-1:0] AccOut,
  output logic [CNT_W-1:0] Count
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_parity;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_fire;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_acc_next;

  // The output slot may be refilled in the same cycle it drains.
  assign InReady  = !r_out_valid || OutReady;
  assign w_accept = InValid && InReady;
  assign w_fire   = r_out_valid && OutReady;

  logic_op_comb #(
    .WIDTH    (WIDTH),
    .ACC_INIT (ACC_INIT)
  ) u_op (
    .A        (A),
    .B        (B),
    .Op       (Op),
    .acc      (r_acc),
    .result   (w_result),
    .acc_next (w_acc_next)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_zero      <= 1'b0;
      r_parity    <= 1'b0;
      r_acc       <= ACC_INIT;
      r_count     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out       <= w_result;
      r_zero      <= ~|w_result;
      r_parity    <= ^w_result;
      if (is_acc_op(Op)) begin
        r_acc <= w_acc_next;
      end
      if (r_count != C_CNT_MAX) begin
        r_count <= r_count + C_CNT_ONE;
      end
    end else if (w_fire) begin
      // Result consumed with nothing new behind it: data and flags hold.
      r_out_valid <= 1'b0;
    end
  end

  assign OutValid = r_out_valid;
  assign Out      = r_out;
  assign Zero     = r_zero;
  assign Parity   = r_parity;
  assign AccOut   = r_acc;
  assign Count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe. Two instances share
//               the stimulus: one with CNT_W=8, one with CNT_W=3 to exercise
//               counter saturation quickly. A behavioural model tracks the
//               expected contents of the output slot, accumulator and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

  localparam int W = 24;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          InValid = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [2:0]    Op = 3'd0;
  logic          OutReady = 1'b0;

  logic          InReady, OutValid, Zero, Parity;
  logic [W-1:0]  Out, AccOut;
  logic [7:0]    Count;

  logic          InReady3, OutValid3, Zero3, Parity3;
  logic [W-1:0]  Out3, AccOut3;
  logic [2:0]    Count3;

  always #5 Clock = ~Clock;

  logic_unit_pipe #(.WIDTH(W), .CNT_W(8), .ACC_INIT('0)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Op(Op), .OutValid(OutValid), .OutReady(OutReady),
    .Out(Out), .Zero(Zero), .Parity(Parity), .AccOut(AccOut), .Count(Count)
  );

  logic_unit_pipe #(.WIDTH(W), .CNT_W(3), .ACC_INIT('0)) dut3 (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady3),
    .A(A), .B(B), .Op(Op), .OutValid(OutValid3), .OutReady(OutReady),
    .Out(Out3), .Zero(Zero3), .Parity(Parity3), .AccOut(AccOut3), .Count(Count3)
  );

  int checks = 0;
  int passes = 0;

  // Reference state: what the output slot should hold.
  bit           m_valid = 0;
  logic [W-1:0] m_out   = '0;
  logic [W-1:0] m_acc   = '0;
  int           m_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ones_parity(input logic [W-1:0] v);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(v[i]);
    return n % 2;
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [2:0] op,
                                           input logic [W-1:0] a, b, acc);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a ^ b);
      3'd5: return ~(a & b);
      3'd6: return acc ^ a ^ b;
      default: return '0;
    endcase
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 32'(OutValid), 32'(m_valid));
    chk({tag, ".out"},   32'(Out),      32'(m_out));
    chk({tag, ".acc"},   32'(AccOut),   32'(m_acc));
    chk({tag, ".cnt"},   32'(Count),    32'((m_cnt > 255) ? 255 : m_cnt));
    chk({tag, ".cnt3"},  32'(Count3),   32'((m_cnt > 7) ? 7 : m_cnt));
    if (m_valid) begin
      chk({tag, ".zero"},   32'(Zero),   32'(m_out == '0));
      chk({tag, ".parity"}, 32'(Parity), 32'(ones_parity(m_out)));
    end
  endtask

  // One clock of stimulus. Called at posedge+1; returns at posedge+1.
  task automatic step(input logic v, input logic [W-1:0] a, b,
                      input logic [2:0] op, input logic rdy);
    bit acc_ev;
    InValid = v; A = a; B = b; Op = op; OutReady = rdy;
    #1;
    chk("inready", 32'(InReady), 32'(!m_valid || rdy));
    acc_ev = v && (!m_valid || rdy);
    @(posedge Clock);
    if (acc_ev) begin
      m_out   = ref_op(op, a, b, m_acc);
      m_valid = 1;
      if (op == 3'd6) m_acc = m_acc ^ a ^ b;
      if (op == 3'd7) m_acc = '0;
      m_cnt++;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    #1;
    check_state("step");
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #2;
    m_valid = 0; m_out = '0; m_acc = '0; m_cnt = 0;
    chk("rst.valid", 32'(OutValid), 32'd0);
    chk("rst.out",   32'(Out),      32'd0);
    chk("rst.zero",  32'(Zero),     32'd0);
    chk("rst.par",   32'(Parity),   32'd0);
    chk("rst.acc",   32'(AccOut),   32'd0);
    chk("rst.cnt",   32'(Count),    32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  logic [W-1:0] held;

  initial begin
    // Test 1: reset, some activity, reset mid-run, then idle.
    @(posedge Clock); #1;
    Reset = 1'b0;
    step(1, 24'h111111, 24'h222222, 3'd2, 1);
    step(1, 24'h000001, 24'h000000, 3'd6, 0);
    do_reset();
    step(0, 24'hABCDEF, 24'h123456, 3'd6, 1);
    chk("idle.inready", 32'(InReady), 32'd1);

    // Test 2: basic ops with OutReady held high.
    step(1, 24'hF0F0F0, 24'h0FF0FF, 3'd2, 1);
    chk("xor.out", 32'(Out), 32'hFF000F);
    step(1, 24'hF0F0F0, 24'h0FF0FF, 3'd0, 1);
    chk("and.out", 32'(Out), 32'h00F0F0);
    chk("and.zero", 32'(Zero), 32'd0);
    step(1, 24'hF0F0F0, 24'h0FF0FF, 3'd3, 1);
    chk("nor.out", 32'(Out), 32'h000F00);
    step(1, 24'h123456, 24'h123456, 3'd4, 1);
    chk("xnor.out", 32'(Out), 32'hFFFFFF);
    chk("xnor.par", 32'(Parity), 32'd0);
    step(1, 24'h123456, 24'h123456, 3'd2, 1);
    chk("xorz.zero", 32'(Zero), 32'd1);
    step(0, '0, '0, 3'd0, 1);

    // Test 3: four XORs with three cycles of backpressure after the first.
    do_reset();
    step(1, 24'h000001, 24'h000010, 3'd2, 1);
    held = Out;
    for (int i = 0; i < 3; i++) begin
      step(1, 24'h000002, 24'h000020, 3'd2, 0);
      chk("bp.hold", 32'(Out), 32'(held));
    end
    step(1, 24'h000002, 24'h000020, 3'd2, 1);
    chk("bp.r2", 32'(Out), 32'h000022);
    step(1, 24'h000003, 24'h000030, 3'd2, 1);
    step(1, 24'h000004, 24'h000040, 3'd2, 1);
    chk("bp.r4", 32'(Out), 32'h000044);
    step(0, '0, '0, 3'd0, 1);
    chk("bp.cnt", 32'(Count), 32'd4);

    // Test 4: accumulator sequence.
    step(1, 24'hFFFFFF, 24'hFFFFFF, 3'd7, 1);
    chk("acc.clr", 32'(Out), 32'h0);
    step(1, 24'h000001, 24'h000000, 3'd6, 1);
    chk("acc.x1", 32'(Out), 32'h1);
    step(1, 24'h000003, 24'h000004, 3'd6, 1);
    chk("acc.x2", 32'(Out), 32'h6);
    chk("acc.val", 32'(AccOut), 32'h6);
    step(1, 24'hFFFFFF, 24'h00FF00, 3'd0, 1);
    chk("acc.and", 32'(AccOut), 32'h6);

    // Test 5: saturation of the 3-bit counter (8 accepts so far).
    for (int i = 0; i < 2; i++) step(1, 24'(i), 24'h5, 3'd1, 1);
    chk("sat.cnt3", 32'(Count3), 32'd7);
    chk("sat.cnt",  32'(Count),  32'd10);

    // Test 6: reset while a result is held under backpressure.
    step(1, 24'h00000F, 24'h000000, 3'd6, 0);
    step(1, 24'h000001, 24'h000001, 3'd2, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, '0, '0, 3'd0, 1);
    chk("rst6.valid", 32'(OutValid), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0),
           W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
